// File: rtl/bus_ready_pkg.sv
// Shared types and widths for the bus ready controller and its helpers.
package bus_ready_pkg;

    localparam int WAIT_COUNT_WIDTH = 4;
    localparam int TIMEOUT_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ready_state_t;

endpackage

// File: rtl/bus_ready_controller_if.sv
// Arbiter-side command strobes in, ready handshakes out.
interface bus_ready_controller_if;

    logic io_read_n;
    logic io_write_n;
    logic memory_read_n;
    logic memory_write_n;
    logic address_enable_n;
    logic dma_wait_n;
    logic io_channel_ready;
    logic processor_ready;
    logic dma_ready;
    logic bus_timeout;

    modport master (
        output io_read_n, io_write_n, memory_read_n, memory_write_n,
        output address_enable_n, dma_wait_n, io_channel_ready,
        input  processor_ready, dma_ready, bus_timeout
    );

    modport slave (
        input  io_read_n, io_write_n, memory_read_n, memory_write_n,
        input  address_enable_n, dma_wait_n, io_channel_ready,
        output processor_ready, dma_ready, bus_timeout
    );

endinterface

// File: rtl/bus_ready_controller_sync.sv
// Two-flop synchronizer for slot-level ready inputs; resets to "ready".
module ready_synchronizer (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_ready_controller.sv
// Wait-state / ready generator for CPU and DMA bus cycles.
// Optional forced release after a stuck WAIT: define READY_TIMEOUT_EN.
module bus_ready_controller
    import bus_ready_pkg::*;
#(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input logic                   clock,
    input logic                   reset_n,
    bus_ready_controller_if.slave bus
);

    localparam logic [WAIT_COUNT_WIDTH-1:0] IO_LOAD  = WAIT_COUNT_WIDTH'(IO_WAIT_STATES);
    localparam logic [WAIT_COUNT_WIDTH-1:0] MEM_LOAD = WAIT_COUNT_WIDTH'(MEM_WAIT_STATES);
    localparam logic [WAIT_COUNT_WIDTH-1:0] CNT_ONE  = WAIT_COUNT_WIDTH'(1);

    if (IO_WAIT_STATES > 15 || MEM_WAIT_STATES > 15 ||
        TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("bus_ready_controller: parameter out of range");
    end

    logic                        cmd_active;
    logic                        cmd_io;
    logic                        start;
    logic                        chan_rdy;
    logic [WAIT_COUNT_WIDTH-1:0] load_n;
    ready_state_t                state_q, state_d;
    logic [WAIT_COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        ready_q, ready_d;
    logic                        cmd_prev_q;
    logic                        proc_rdy_q, dma_rdy_q;
    logic                        tmo_fire, tmo_hit, tmo_pulse_q;

    assign cmd_active = ~(bus.io_read_n & bus.io_write_n & bus.memory_read_n & bus.memory_write_n);
    assign cmd_io     = ~(bus.io_read_n & bus.io_write_n);
    assign start      = cmd_active & ~cmd_prev_q;
    assign load_n     = cmd_io ? IO_LOAD : MEM_LOAD;

    ready_synchronizer u_chan_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (bus.io_channel_ready),
        .q_o    (chan_rdy)
    );

`ifdef READY_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    // tmo_cnt_q counts completed WAIT cycles, so the last one is TIMEOUT_CYCLES-1
    assign tmo_fire = (state_q == WAIT) && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE && start)
            tmo_cnt_d = '0;
        else if (state_q == WAIT)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        tmo_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    if (load_n == '0 && chan_rdy) begin
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = load_n;
                        ready_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (!cmd_active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else if (cnt_q <= CNT_ONE && chan_rdy) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else if (tmo_fire) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    tmo_hit = 1'b1;
                end else if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            HOLD: begin
                ready_d = 1'b1;
                if (!cmd_active) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            cmd_prev_q  <= 1'b0;
            proc_rdy_q  <= 1'b1;
            dma_rdy_q   <= 1'b1;
            tmo_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            cmd_prev_q  <= cmd_active;
            // ownership only steers which requester sees the wait
            proc_rdy_q  <= bus.dma_wait_n & (bus.address_enable_n | ready_d);
            dma_rdy_q   <= ~bus.address_enable_n | ready_d;
            tmo_pulse_q <= tmo_hit;
        end
    end

    assign bus.processor_ready = proc_rdy_q;
    assign bus.dma_ready       = dma_rdy_q;
    assign bus.bus_timeout     = tmo_pulse_q;

endmodule

// File: tb/tb_bus_ready_controller.sv
// Directed bench: DUT A (IO=1, MEM=0, timeout 16) and DUT B (IO=4, MEM=2) share stimulus.
module tb_bus_ready_controller;

`ifdef READY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   passes = 0;

    bus_ready_controller_if ifa ();
    bus_ready_controller_if ifb ();

    bus_ready_controller #(.IO_WAIT_STATES(1), .MEM_WAIT_STATES(0), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    bus_ready_controller #(.IO_WAIT_STATES(4), .MEM_WAIT_STATES(2), .TIMEOUT_CYCLES(255)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic rst, iord, iowr, mrd, mwr, aen, dw, chr;
        logic p, d;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    // Drive both DUTs, clock once, sample 1ns after the edge.
    task automatic apply(input logic rst, iord, iowr, mrd, mwr, aen, dw, chr);
        reset_n = rst;
        ifa.io_read_n = iord; ifa.io_write_n = iowr; ifa.memory_read_n = mrd; ifa.memory_write_n = mwr;
        ifa.address_enable_n = aen; ifa.dma_wait_n = dw; ifa.io_channel_ready = chr;
        ifb.io_read_n = iord; ifb.io_write_n = iowr; ifb.memory_read_n = mrd; ifb.memory_write_n = mwr;
        ifb.address_enable_n = aen; ifb.dma_wait_n = dw; ifb.io_channel_ready = chr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic ep, ed, rdy, strb;
        //             rst iord iowr mrd mwr aen dw chr  p  d
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1}; // reset
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1}; // idle
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1}; // io read: 1 wait
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1}; // held, no restart
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1}; // mem write: 0 waits
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1}; // io+mem: io count wins
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0}; // dma mem->io
        tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1};
        tbl[15] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1};
        tbl[16] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
        tbl[17] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1}; // dma_wait_n holds cpu
        tbl[18] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};

        reset_n = 1'b0;
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].rst, tbl[i].iord, tbl[i].iowr, tbl[i].mrd, tbl[i].mwr,
                  tbl[i].aen, tbl[i].dw, tbl[i].chr);
            chk($sformatf("vec%0d prdy", i), ifa.processor_ready, tbl[i].p);
            chk($sformatf("vec%0d drdy", i), ifa.dma_ready, tbl[i].d);
            chk($sformatf("vec%0d tmo", i), ifa.bus_timeout, 1'b0);
            if (i < 2) chk($sformatf("vec%0d B prdy", i), ifb.processor_ready, 1'b1);
        end

        // channel low 10 vectors from i=0, io write from i=2; ownership flips in WAIT at i=6,7
        for (int i = 0; i < 15; i++) begin
            strb = !(i >= 2 && i <= 12);
            apply(1'b1, 1'b1, strb, 1'b1, 1'b1, (i == 6 || i == 7), 1'b1, (i >= 10));
            rdy = !(i >= 2 && i <= 11);
            ep  = (i == 6 || i == 7) ? 1'b1 : rdy;
            ed  = (i == 6 || i == 7) ? rdy : 1'b1;
            chk($sformatf("chan%0d prdy", i), ifa.processor_ready, ep);
            chk($sformatf("chan%0d drdy", i), ifa.dma_ready, ed);
        end

        // B: io read, 4 waits
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, (i == 6), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("b_io%0d prdy", i), ifb.processor_ready, (i >= 4));
            chk($sformatf("b_io%0d drdy", i), ifb.dma_ready, 1'b1);
        end
        // B: mem write, 2 waits
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, (i == 3), 1'b0, 1'b1, 1'b1);
            chk($sformatf("b_mem%0d prdy", i), ifb.processor_ready, (i >= 2));
        end
        // B: strobe dropped after 2 wait clocks
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, (i >= 2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("b_abort%0d prdy", i), ifb.processor_ready, (i >= 2));
        end
        // B: reset pulse during WAIT
        for (int i = 0; i < 4; i++) begin
            apply((i != 2), (i >= 3), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("b_rst%0d prdy", i), ifb.processor_ready, (i >= 2));
            chk($sformatf("b_rst%0d drdy", i), ifb.dma_ready, 1'b1);
            if (i == 2) begin
                chk("a_rst prdy", ifa.processor_ready, 1'b1);
                chk("a_rst drdy", ifa.dma_ready, 1'b1);
            end
        end

        // A: channel stuck low, io read from i=2 to i=20
        for (int i = 0; i < 22; i++) begin
            strb = !(i >= 2 && i <= 20);
            apply(1'b1, strb, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            ep = TMO_EN ? (i < 2 || i >= 18) : (i < 2 || i >= 21);
            chk($sformatf("stuck%0d prdy", i), ifa.processor_ready, ep);
            chk($sformatf("stuck%0d tmo", i), ifa.bus_timeout, TMO_EN && (i == 18));
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("tail%0d prdy", i), ifa.processor_ready, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
